// File: rtl/bp_cfg_table.sv
// Per-core configuration table: host writes shadow words, commits copy a whole
// shadow bank to the active outputs under a freeze/ack handshake with the core.
module bp_cfg_table #(
    parameter int unsigned num_core_p       = 4,
    parameter int unsigned cfg_addr_width_p = 4,
    parameter int unsigned cfg_data_width_p = 32,
    parameter logic [cfg_data_width_p-1:0] reset_val_p = '0,
    localparam int unsigned core_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1,
    localparam int unsigned words_lp      = 1 << cfg_addr_width_p
) (
    input  logic                                             clk_i,
    input  logic                                             reset_n_i,
    input  logic                                             cmd_v_i,
    output logic                                             cmd_ready_o,
    input  logic [1:0]                                       cmd_op_i,
    input  logic [core_width_lp-1:0]                         cmd_core_i,
    input  logic [cfg_addr_width_p-1:0]                      cmd_addr_i,
    input  logic [cfg_data_width_p-1:0]                      cmd_data_i,
    output logic                                             resp_v_o,
    input  logic                                             resp_yumi_i,
    output logic [cfg_data_width_p-1:0]                      resp_data_o,
    output logic [num_core_p-1:0]                            freeze_o,
    input  logic [num_core_p-1:0]                            freeze_ack_i,
    output logic [num_core_p*words_lp*cfg_data_width_p-1:0]  cfg_o,
    output logic                                             busy_o
);

    typedef enum logic [2:0] {
        e_ready   = 3'd0,
        e_freeze  = 3'd1,
        e_apply   = 3'd2,
        e_release = 3'd3,
        e_resp    = 3'd4
    } state_e;

    state_e                        state_q, state_d;
    logic [core_width_lp-1:0]      core_q, core_d;
    logic [cfg_data_width_p-1:0]   resp_data_q, resp_data_d;
    logic [num_core_p-1:0]         freeze_q, freeze_d;
    logic                          cmd_ready_q, resp_v_q, busy_q;
    logic                          shadow_we;
    logic                          in_range;

    logic [cfg_data_width_p-1:0]   shadow_q [num_core_p][words_lp];
    logic [cfg_data_width_p-1:0]   active_q [num_core_p][words_lp];

    assign in_range = ({1'b0, cmd_core_i} < (core_width_lp + 1)'(num_core_p));

    // State and registered outputs
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= e_ready;
            core_q      <= '0;
            resp_data_q <= '0;
            freeze_q    <= '0;
            cmd_ready_q <= 1'b1;
            resp_v_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            core_q      <= core_d;
            resp_data_q <= resp_data_d;
            freeze_q    <= freeze_d;
            cmd_ready_q <= (state_d == e_ready);
            resp_v_q    <= (state_d == e_resp);
            busy_q      <= (state_d != e_ready);
        end
    end

    // Next state, response data and freeze request
    always_comb begin
        state_d     = state_q;
        core_d      = core_q;
        resp_data_d = resp_data_q;
        shadow_we   = 1'b0;
        freeze_d    = '0;
        case (state_q)
            e_ready: begin
                if (cmd_v_i) begin
                    state_d = e_resp;
                    case (cmd_op_i)
                        2'd1: begin
                            shadow_we   = in_range;
                            resp_data_d = cmd_data_i;
                        end
                        2'd2: begin
                            resp_data_d = '0;
                            if (in_range) begin
                                core_d  = cmd_core_i;
                                state_d = e_freeze;
                            end
                        end
                        default: begin
                            resp_data_d = in_range ? active_q[cmd_core_i][cmd_addr_i] : '0;
                        end
                    endcase
                end
            end
            e_freeze: begin
                if (freeze_ack_i[core_q]) state_d = e_apply;
            end
            e_apply: state_d = e_release;
            e_release: begin
                if (!freeze_ack_i[core_q]) begin
                    resp_data_d = '0;
                    state_d     = e_resp;
                end
            end
            e_resp: begin
                if (resp_yumi_i) state_d = e_ready;
            end
            default: state_d = e_ready;
        endcase
        if (state_d == e_freeze || state_d == e_apply) freeze_d[core_d] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned c = 0; c < num_core_p; c++)
                for (int unsigned w = 0; w < words_lp; w++)
                    shadow_q[c][w] <= reset_val_p;
        end else if (shadow_we) begin
            shadow_q[cmd_core_i][cmd_addr_i] <= cmd_data_i;
        end
    end

    // Whole bank copied on the single e_apply edge, so no partial update is visible
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned c = 0; c < num_core_p; c++)
                for (int unsigned w = 0; w < words_lp; w++)
                    active_q[c][w] <= reset_val_p;
        end else if (state_q == e_apply) begin
            for (int unsigned w = 0; w < words_lp; w++)
                active_q[core_q][w] <= shadow_q[core_q][w];
        end
    end

    for (genvar c = 0; c < num_core_p; c++) begin : g_core
        for (genvar w = 0; w < words_lp; w++) begin : g_word
            assign cfg_o[(c*words_lp+w)*cfg_data_width_p +: cfg_data_width_p] = active_q[c][w];
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign resp_v_o    = resp_v_q;
    assign resp_data_o = resp_data_q;
    assign freeze_o    = freeze_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_bp_cfg_table.sv
// Directed bench for bp_cfg_table: 3 cores, 16 words of 32 bits, reset value 0xA5.
module tb_bp_cfg_table;

    localparam int unsigned NC = 3;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned NW = 1 << AW;
    localparam logic [DW-1:0] RV = 32'h0000_00A5;

    logic              clk, reset_n;
    logic              cmd_v, cmd_ready;
    logic [1:0]        cmd_op;
    logic [1:0]        cmd_core;
    logic [AW-1:0]     cmd_addr;
    logic [DW-1:0]     cmd_data;
    logic              resp_v, resp_yumi;
    logic [DW-1:0]     resp_data;
    logic [NC-1:0]     freeze, freeze_ack, ack_manual;
    logic              ack_follow;
    logic [NC*NW*DW-1:0] cfg;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    bp_cfg_table #(
        .num_core_p(NC), .cfg_addr_width_p(AW), .cfg_data_width_p(DW), .reset_val_p(RV)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_core_i(cmd_core), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
        .resp_v_o(resp_v), .resp_yumi_i(resp_yumi), .resp_data_o(resp_data),
        .freeze_o(freeze), .freeze_ack_i(freeze_ack), .cfg_o(cfg), .busy_o(busy)
    );

    assign freeze_ack = ack_follow ? freeze : ack_manual;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  core;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        int          hold;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [31:0] cw(input int c, input int w);
        return cfg[(c*NW+w)*DW +: DW];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    task automatic chk_all_cfg(input string name, input logic [31:0] exp);
        int bad = 0;
        for (int c = 0; c < NC; c++)
            for (int w = 0; w < NW; w++)
                if (cw(c, w) !== exp) bad++;
        chk(name, 32'(bad), 32'd0);
    endtask

    // One command: issue at a negedge, wait for the response, hold off yumi for 'hold' cycles
    task automatic do_cmd(input string name, input logic [1:0] op, input logic [1:0] core,
                          input logic [3:0] addr, input logic [31:0] data,
                          input logic [31:0] exp, input int hold);
        int n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) begin timeout({name, " ready"}); return; end
        cmd_v = 1'b1; cmd_op = op; cmd_core = core; cmd_addr = addr; cmd_data = data;
        @(negedge clk);
        cmd_v = 1'b0;
        n = 0;
        while (!resp_v && n < 100) begin @(negedge clk); n++; end
        if (!resp_v) begin timeout({name, " resp"}); return; end
        if (op != 2'd2) chk({name, " latency"}, 32'(n), 32'd0);
        chk({name, " data"}, resp_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, " held resp_v"}, 32'(resp_v), 32'd1);
            chk({name, " held data"}, resp_data, exp);
            chk({name, " held ready"}, 32'(cmd_ready), 32'd0);
        end
        resp_yumi = 1'b1;
        @(negedge clk);
        resp_yumi = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; cmd_v = 1'b0; cmd_op = '0; cmd_core = '0; cmd_addr = '0;
        cmd_data = '0; resp_yumi = 1'b0; ack_follow = 1'b1; ack_manual = '0;

        vecs[0] = '{2'd1, 2'd1, 4'd3,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0};
        vecs[1] = '{2'd0, 2'd1, 4'd3,  32'h0,         RV,            0};
        vecs[2] = '{2'd1, 2'd0, 4'd0,  32'h1111_2222, 32'h1111_2222, 0};
        vecs[3] = '{2'd0, 2'd0, 4'd0,  32'h0,         RV,            0};
        vecs[4] = '{2'd3, 2'd1, 4'd3,  32'h0,         RV,            0};
        vecs[5] = '{2'd1, 2'd3, 4'd2,  32'h0000_1234, 32'h0000_1234, 0};
        vecs[6] = '{2'd0, 2'd3, 4'd2,  32'h0,         32'h0,         0};
        vecs[7] = '{2'd1, 2'd2, 4'd15, 32'hCAFE_F00D, 32'hCAFE_F00D, 2};
        vecs[8] = '{2'd0, 2'd2, 4'd15, 32'h0,         RV,            0};

        @(negedge clk);
        chk("reset ready", 32'(cmd_ready), 32'd1);
        chk("reset resp_v", 32'(resp_v), 32'd0);
        chk("reset freeze", 32'(freeze), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk_all_cfg("reset cfg", RV);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            do_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].core, vecs[i].addr,
                   vecs[i].data, vecs[i].exp, vecs[i].hold);
        chk_all_cfg("cfg before commit", RV);

        // Commit core 1 with ack mirroring freeze
        cmd_v = 1'b1; cmd_op = 2'd2; cmd_core = 2'd1; cmd_addr = '0; cmd_data = '0;
        @(negedge clk);
        cmd_v = 1'b0;
        chk("commit t+1 freeze", 32'(freeze), 32'b010);
        chk("commit t+1 ready", 32'(cmd_ready), 32'd0);
        chk("commit t+1 busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("commit t+2 freeze", 32'(freeze), 32'b010);
        chk("commit t+2 cfg", cw(1, 3), RV);
        @(negedge clk);
        chk("commit t+3 freeze", 32'(freeze), 32'd0);
        chk("commit t+3 cfg", cw(1, 3), 32'hDEAD_BEEF);
        chk("commit t+3 resp_v", 32'(resp_v), 32'd0);
        chk("commit other core", cw(0, 0), RV);
        @(negedge clk);
        chk("commit t+4 resp_v", 32'(resp_v), 32'd1);
        chk("commit t+4 data", resp_data, 32'd0);
        resp_yumi = 1'b1;
        @(negedge clk);
        resp_yumi = 1'b0;
        do_cmd("read committed", 2'd0, 2'd1, 4'd3, 32'h0, 32'hDEAD_BEEF, 0);

        // Delayed ack, other-core acks ignored, release stalls on stuck ack
        do_cmd("write 55aa", 2'd1, 2'd1, 4'd3, 32'h55AA_55AA, 32'h55AA_55AA, 0);
        ack_follow = 1'b0; ack_manual = '0;
        cmd_v = 1'b1; cmd_op = 2'd2; cmd_core = 2'd1;
        @(negedge clk);
        cmd_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("wait ack freeze", 32'(freeze), 32'b010);
            chk("wait ack cfg", cw(1, 3), 32'hDEAD_BEEF);
            chk("wait ack ready", 32'(cmd_ready), 32'd0);
            if (i == 4) ack_manual = 3'b101;
            @(negedge clk);
        end
        ack_manual = 3'b010;
        @(negedge clk);
        chk("apply freeze", 32'(freeze), 32'b010);
        chk("apply cfg old", cw(1, 3), 32'hDEAD_BEEF);
        @(negedge clk);
        chk("release freeze", 32'(freeze), 32'd0);
        chk("release cfg new", cw(1, 3), 32'h55AA_55AA);
        for (int i = 0; i < 3; i++) begin
            chk("stuck ack resp_v", 32'(resp_v), 32'd0);
            chk("stuck ack busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        ack_manual = '0;
        @(negedge clk);
        chk("late release resp_v", 32'(resp_v), 32'd1);
        chk("late release data", resp_data, 32'd0);
        resp_yumi = 1'b1;
        @(negedge clk);
        resp_yumi = 1'b0;
        ack_follow = 1'b1;
        do_cmd("backpressure read", 2'd0, 2'd1, 4'd3, 32'h0, 32'h55AA_55AA, 5);

        // Out-of-range commit skips the handshake
        cmd_v = 1'b1; cmd_op = 2'd2; cmd_core = 2'd3;
        @(negedge clk);
        cmd_v = 1'b0;
        chk("oor commit freeze", 32'(freeze), 32'd0);
        chk("oor commit resp_v", 32'(resp_v), 32'd1);
        chk("oor commit data", resp_data, 32'd0);
        resp_yumi = 1'b1;
        @(negedge clk);
        resp_yumi = 1'b0;
        chk("oor commit cfg", cw(2, 15), RV);

        // Reset while frozen
        do_cmd("write c2", 2'd1, 2'd2, 4'd5, 32'h0000_0077, 32'h0000_0077, 0);
        ack_follow = 1'b0; ack_manual = '0;
        cmd_v = 1'b1; cmd_op = 2'd2; cmd_core = 2'd2;
        @(negedge clk);
        cmd_v = 1'b0;
        chk("pre-reset freeze", 32'(freeze), 32'b100);
        #2 reset_n = 1'b0;
        #1;
        chk("mid reset freeze", 32'(freeze), 32'd0);
        chk("mid reset ready", 32'(cmd_ready), 32'd1);
        chk("mid reset resp_v", 32'(resp_v), 32'd0);
        chk("mid reset busy", 32'(busy), 32'd0);
        chk("mid reset data", resp_data, 32'd0);
        chk_all_cfg("mid reset cfg", RV);
        @(negedge clk);
        reset_n = 1'b1;
        ack_follow = 1'b1;
        @(negedge clk);
        do_cmd("post reset commit", 2'd2, 2'd2, 4'd0, 32'h0, 32'h0, 0);
        do_cmd("post reset read c2", 2'd0, 2'd2, 4'd5, 32'h0, RV, 0);
        do_cmd("post reset read c1", 2'd0, 2'd1, 4'd3, 32'h0, RV, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
